// File: rtl/cnn_pkg.sv
// Shared constants and encodings for the CNN accelerator stream interfaces.
package cnn_pkg;

  localparam int unsigned CNN_PSUM_WIDTH      = 1280;
  localparam int unsigned CNN_AXIS_DATA_WIDTH = 32;
  localparam int unsigned CNN_BEATS_PER_PSUM  = CNN_PSUM_WIDTH / CNN_AXIS_DATA_WIDTH;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/psum_vec_fifo.sv
// Small synchronous vector FIFO with registered empty and write-ready (not full) flags.
module psum_vec_fifo #(
  parameter int unsigned WIDTH = 1280,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("psum_vec_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             empty_q, empty_d;
  logic             wr_ready_q, wr_ready_d;
  logic             do_push, do_pop;

  assign do_push  = push & wr_ready_q;
  assign do_pop   = pop & ~empty_q;
  assign wr_ready = wr_ready_q;
  assign empty    = empty_q;
  assign rd_data  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    cnt_d      = cnt_q + CW'(do_push) - CW'(do_pop);
    empty_d    = (cnt_d == '0);
    wr_ready_d = (cnt_d != CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      empty_q    <= 1'b1;
      wr_ready_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      empty_q    <= empty_d;
      wr_ready_q <= wr_ready_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/psum_axis_tx.sv
// AXI4-Stream master: buffers psum vectors and serializes them into beats, lowest word
// first, with TLAST on the final beat of every frame_len-vector packet.
module psum_axis_tx
  import cnn_pkg::*;
#(
  parameter int unsigned PSUM_WIDTH           = CNN_PSUM_WIDTH,
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = CNN_AXIS_DATA_WIDTH,
  parameter int unsigned VEC_FIFO_DEPTH       = 2,
  parameter int unsigned FRAME_LEN_WIDTH      = 12
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PSUM_WIDTH-1:0]             psum_in,
  input  logic                              psum_in_valid,
  output logic                              psum_in_ready,
  input  logic [FRAME_LEN_WIDTH-1:0]        frame_len,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  output logic                              tx_busy,
  output logic                              packet_done
);

  localparam int unsigned BEATS = PSUM_WIDTH / C_M_AXIS_TDATA_WIDTH;
  localparam int unsigned BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

  if ((PSUM_WIDTH % C_M_AXIS_TDATA_WIDTH) != 0) begin : g_bad_width
    $error("psum_axis_tx: PSUM_WIDTH must be a multiple of C_M_AXIS_TDATA_WIDTH");
  end

  logic [PSUM_WIDTH-1:0]      fifo_head;
  logic                       fifo_empty;
  logic                       fifo_wr_ready;
  logic                       fifo_pop;

  tx_state_e                  state_q, state_d;
  logic [PSUM_WIDTH-1:0]      shift_q, shift_d;
  logic [BCW-1:0]             beat_cnt_q, beat_cnt_d;
  logic [FRAME_LEN_WIDTH-1:0] vec_cnt_q, vec_cnt_d;
  logic [FRAME_LEN_WIDTH-1:0] len_q, len_d;
  logic                       tvalid_q, tvalid_d;
  logic                       tlast_q, tlast_d;
  logic                       packet_done_q, packet_done_d;

  psum_vec_fifo #(
    .WIDTH (PSUM_WIDTH),
    .DEPTH (VEC_FIFO_DEPTH)
  ) u_vec_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (psum_in_valid),
    .wr_data  (psum_in),
    .wr_ready (fifo_wr_ready),
    .pop      (fifo_pop),
    .rd_data  (fifo_head),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    beat_cnt_d    = beat_cnt_q;
    vec_cnt_d     = vec_cnt_q;
    len_d         = len_q;
    packet_done_d = 1'b0;
    fifo_pop      = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (vec_cnt_q == '0) begin
          len_d = (frame_len == '0) ? FRAME_LEN_WIDTH'(1) : frame_len;
        end
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_d    = fifo_head;
          beat_cnt_d = '0;
          state_d    = TX_SEND;
        end
      end
      TX_SEND: begin
        if (M_AXIS_TREADY) begin
          shift_d    = shift_q >> C_M_AXIS_TDATA_WIDTH;
          beat_cnt_d = beat_cnt_q + BCW'(1);
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            if (vec_cnt_q == len_q - FRAME_LEN_WIDTH'(1)) begin
              vec_cnt_d     = '0;
              packet_done_d = 1'b1;
            end else begin
              vec_cnt_d = vec_cnt_q + FRAME_LEN_WIDTH'(1);
            end
            // Reload on the same edge as the final handshake keeps back-to-back vectors bubble-free.
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_head;
            end else begin
              state_d = TX_IDLE;
            end
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
    tvalid_d = (state_d == TX_SEND);
    tlast_d  = (state_d == TX_SEND) && (beat_cnt_d == LAST_BEAT) &&
               (vec_cnt_d == len_d - FRAME_LEN_WIDTH'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= TX_IDLE;
      shift_q       <= '0;
      beat_cnt_q    <= '0;
      vec_cnt_q     <= '0;
      len_q         <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      packet_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      beat_cnt_q    <= beat_cnt_d;
      vec_cnt_q     <= vec_cnt_d;
      len_q         <= len_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      packet_done_q <= packet_done_d;
    end
  end

  assign psum_in_ready = fifo_wr_ready;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TDATA  = shift_q[C_M_AXIS_TDATA_WIDTH-1:0];
  assign M_AXIS_TSTRB  = {(C_M_AXIS_TDATA_WIDTH/8){tvalid_q}};
  assign M_AXIS_TLAST  = tlast_q;
  assign packet_done   = packet_done_q;
  assign tx_busy       = (state_q == TX_SEND) | ~fifo_empty;

endmodule
